// File: rtl/silent_lpf_v3_pkg.sv
// Shared types and helpers for the step-limited duty/phase slew filter.
package silent_lpf_v3_pkg;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PROCESS = 1'b1
    } state_e;

    // read -> diff -> clamp/add
    localparam int unsigned LAT = 3;

    // Diff container sized for the widest supported WIDTH plus a sign bit.
    localparam int unsigned MAX_WIDTH = 16;
    typedef logic signed [MAX_WIDTH:0] diff_t;

    function automatic int unsigned ngroups(input int unsigned trans_num, input int unsigned lanes);
        return (trans_num + lanes - 1) / lanes;
    endfunction

    // A zero step means jump straight to the target.
    function automatic diff_t clamp_step(input diff_t d, input diff_t step);
        diff_t r;
        r = d;
        if (step != '0) begin
            if (d > step)       r = step;
            else if (d < -step) r = -step;
        end
        return r;
    endfunction

endpackage

// File: rtl/silent_lpf_v3_if.sv
// Control, target and filtered-output bundle of the slew filter.
interface silent_lpf_v3_if #(
    parameter int unsigned TRANS_NUM = 249,
    parameter int unsigned WIDTH     = 8
) ();

    logic             i_enable;
    logic             i_update;
    logic [WIDTH-1:0] i_step_duty;
    logic [WIDTH-1:0] i_step_phase;
    logic [WIDTH-1:0] i_duty     [TRANS_NUM];
    logic [WIDTH-1:0] i_phase    [TRANS_NUM];
    logic [WIDTH-1:0] o_dutys_c  [TRANS_NUM];
    logic [WIDTH-1:0] o_phases_c [TRANS_NUM];
    logic             o_out_valid;
    logic             o_settled;
    logic             o_busy;

    modport master (
        output i_enable, i_update, i_step_duty, i_step_phase, i_duty, i_phase,
        input  o_dutys_c, o_phases_c, o_out_valid, o_settled, o_busy
    );

    modport slave (
        input  i_enable, i_update, i_step_duty, i_step_phase, i_duty, i_phase,
        output o_dutys_c, o_phases_c, o_out_valid, o_settled, o_busy
    );

endinterface

// File: rtl/silent_lpf_v3_lane.sv
// One lane of the filter: registered read, registered diff, then clamp+add
// presented combinationally for writeback at the third edge.
module silent_lpf_v3_lane
    import silent_lpf_v3_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_cur_duty,
    input  logic [WIDTH-1:0] i_tgt_duty,
    input  logic [WIDTH-1:0] i_cur_phase,
    input  logic [WIDTH-1:0] i_tgt_phase,
    input  logic [WIDTH-1:0] i_step_duty,
    input  logic [WIDTH-1:0] i_step_phase,
    output logic [WIDTH-1:0] o_new_duty_c,
    output logic [WIDTH-1:0] o_new_phase_c,
    output logic             o_nz_c
);

    localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] r_cur_d1, r_tgt_d1, r_cur_p1, r_tgt_p1;
    logic [WIDTH-1:0] r_cur_d2, r_cur_p2;
    diff_t            r_dd, r_dp;

    logic [WIDTH-1:0] w_praw;
    diff_t            w_dd, w_dp, w_adj_d, w_adj_p;

    // Phase diff is the modular difference read as signed; a half turn is
    // forced positive so the direction is deterministic.
    always_comb begin
        w_dd   = diff_t'(r_tgt_d1) - diff_t'(r_cur_d1);
        w_praw = r_tgt_p1 - r_cur_p1;
        if (w_praw == HALF) w_dp = diff_t'(w_praw);
        else                w_dp = diff_t'(signed'(w_praw));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_d1 <= '0;
            r_tgt_d1 <= '0;
            r_cur_p1 <= '0;
            r_tgt_p1 <= '0;
            r_cur_d2 <= '0;
            r_cur_p2 <= '0;
            r_dd     <= '0;
            r_dp     <= '0;
        end else begin
            r_cur_d1 <= i_cur_duty;
            r_tgt_d1 <= i_tgt_duty;
            r_cur_p1 <= i_cur_phase;
            r_tgt_p1 <= i_tgt_phase;
            r_cur_d2 <= r_cur_d1;
            r_cur_p2 <= r_cur_p1;
            r_dd     <= w_dd;
            r_dp     <= w_dp;
        end
    end

    // Duty result stays in range by construction; phase wraps by truncation.
    always_comb begin
        w_adj_d       = clamp_step(r_dd, diff_t'(i_step_duty));
        w_adj_p       = clamp_step(r_dp, diff_t'(i_step_phase));
        o_new_duty_c  = WIDTH'(diff_t'(r_cur_d2) + w_adj_d);
        o_new_phase_c = WIDTH'(diff_t'(r_cur_p2) + w_adj_p);
        o_nz_c        = (w_adj_d != '0) || (w_adj_p != '0);
    end

endmodule

// File: rtl/silent_lpf_v3.sv
// Step-limited slew filter moving per-transducer duty/phase toward latched
// targets, LANES transducers per cycle, with a one-deep update queue.
module silent_lpf_v3
    import silent_lpf_v3_pkg::*;
#(
    parameter int unsigned TRANS_NUM = 249,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned LANES     = 1
) (
    input  logic           clk,
    input  logic           rst,
    silent_lpf_v3_if.slave bus
);

    localparam int unsigned NG    = ngroups(TRANS_NUM, LANES);
    localparam int unsigned CNT_W = $clog2(NG + LAT);
    localparam int unsigned IDX_W = (TRANS_NUM > 1) ? $clog2(TRANS_NUM) : 1;

    state_e           r_state, w_state_nxt;
    logic             w_accept, w_last_wb;

    logic [CNT_W-1:0] r_g, r_g1, r_g2;
    logic             r_v1, r_v2;
    logic             r_pend, r_acc, r_out_valid, r_settled, r_busy;

    logic [WIDTH-1:0] r_step_d, r_step_p;
    logic [WIDTH-1:0] r_tgt_d [TRANS_NUM];
    logic [WIDTH-1:0] r_tgt_p [TRANS_NUM];
    logic [WIDTH-1:0] r_cur_d [TRANS_NUM];
    logic [WIDTH-1:0] r_cur_p [TRANS_NUM];

    logic [WIDTH-1:0] w_rd_cur_d [LANES];
    logic [WIDTH-1:0] w_rd_tgt_d [LANES];
    logic [WIDTH-1:0] w_rd_cur_p [LANES];
    logic [WIDTH-1:0] w_rd_tgt_p [LANES];
    logic [WIDTH-1:0] w_new_d    [LANES];
    logic [WIDTH-1:0] w_new_p    [LANES];
    logic             w_nz       [LANES];
    logic [IDX_W-1:0] w_wb_idx   [LANES];
    logic             w_wb_ok    [LANES];
    logic             w_nz_any;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // The last group's writeback is LAT-1 cycles after it was read.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last_wb   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_update || r_pend) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_PROCESS;
                end
            end
            S_PROCESS: begin
                if (r_g == CNT_W'(NG + LAT - 2)) begin
                    w_last_wb   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Read selection for the group being issued and lane masking for the
    // group being written back; lanes past TRANS_NUM read zero and never write.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            int unsigned rd_idx;
            int unsigned wb_idx;
            rd_idx        = 32'(r_g) * LANES + 32'(l);
            wb_idx        = 32'(r_g2) * LANES + 32'(l);
            w_rd_cur_d[l] = '0;
            w_rd_tgt_d[l] = '0;
            w_rd_cur_p[l] = '0;
            w_rd_tgt_p[l] = '0;
            if (rd_idx < TRANS_NUM) begin
                w_rd_cur_d[l] = r_cur_d[IDX_W'(rd_idx)];
                w_rd_tgt_d[l] = r_tgt_d[IDX_W'(rd_idx)];
                w_rd_cur_p[l] = r_cur_p[IDX_W'(rd_idx)];
                w_rd_tgt_p[l] = r_tgt_p[IDX_W'(rd_idx)];
            end
            w_wb_ok[l]  = wb_idx < TRANS_NUM;
            w_wb_idx[l] = IDX_W'(wb_idx);
        end
    end

    always_comb begin
        w_nz_any = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            w_nz_any = w_nz_any | (w_wb_ok[l] & w_nz[l]);
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        silent_lpf_v3_lane #(.WIDTH(WIDTH)) u_lane (
            .clk          (clk),
            .rst          (rst),
            .i_cur_duty   (w_rd_cur_d[l]),
            .i_tgt_duty   (w_rd_tgt_d[l]),
            .i_cur_phase  (w_rd_cur_p[l]),
            .i_tgt_phase  (w_rd_tgt_p[l]),
            .i_step_duty  (r_step_d),
            .i_step_phase (r_step_p),
            .o_new_duty_c (w_new_d[l]),
            .o_new_phase_c(w_new_p[l]),
            .o_nz_c       (w_nz[l])
        );
    end

    // Pass control, group sequencing and target capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_g         <= '0;
            r_g1        <= '0;
            r_g2        <= '0;
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_pend      <= 1'b0;
            r_acc       <= 1'b0;
            r_out_valid <= 1'b0;
            r_settled   <= 1'b0;
            r_busy      <= 1'b0;
            r_step_d    <= '0;
            r_step_p    <= '0;
            for (int i = 0; i < TRANS_NUM; i++) begin
                r_tgt_d[i] <= '0;
                r_tgt_p[i] <= '0;
            end
        end else begin
            r_busy <= (w_state_nxt == S_PROCESS);
            r_v1   <= (r_state == S_PROCESS) && (r_g < CNT_W'(NG));
            r_g1   <= r_g;
            r_v2   <= r_v1;
            r_g2   <= r_g1;

            if (w_accept)                     r_g <= '0;
            else if (r_state == S_PROCESS)    r_g <= r_g + CNT_W'(1);

            if (w_accept)                                 r_pend <= 1'b0;
            else if (r_state == S_PROCESS && bus.i_update) r_pend <= 1'b1;

            if (w_accept)                 r_acc <= 1'b0;
            else if (r_v2 && w_nz_any)    r_acc <= 1'b1;

            if (w_accept)       r_out_valid <= 1'b0;
            else if (w_last_wb) r_out_valid <= 1'b1;

            if (w_last_wb) r_settled <= ~(r_acc | (r_v2 & w_nz_any));

            if (w_accept) begin
                r_step_d <= bus.i_step_duty;
                r_step_p <= bus.i_step_phase;
                for (int i = 0; i < TRANS_NUM; i++) begin
                    r_tgt_d[i] <= bus.i_duty[i];
                    r_tgt_p[i] <= bus.i_phase[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TRANS_NUM; i++) begin
                r_cur_d[i] <= '0;
                r_cur_p[i] <= '0;
            end
        end else if (r_v2) begin
            for (int l = 0; l < LANES; l++) begin
                if (w_wb_ok[l]) begin
                    r_cur_d[w_wb_idx[l]] <= w_new_d[l];
                    r_cur_p[w_wb_idx[l]] <= w_new_p[l];
                end
            end
        end
    end

    // Bypass leaves the current registers running; only the view changes.
    always_comb begin
        for (int i = 0; i < TRANS_NUM; i++) begin
            bus.o_dutys_c[i]  = bus.i_enable ? r_cur_d[i] : bus.i_duty[i];
            bus.o_phases_c[i] = bus.i_enable ? r_cur_p[i] : bus.i_phase[i];
        end
    end

    assign bus.o_out_valid = r_out_valid;
    assign bus.o_settled   = r_settled;
    assign bus.o_busy      = r_busy;

endmodule
